seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_glyph_rom.sv | 36 +++
 rtl/seg_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg_scan_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared glyph codes, blank pattern and per-digit record for the
// multiplexed seven-segment scan driver.
package seg_pkg;

   localparam logic [4:0] GLYPH_H     = 5'd16;
   localparam logic [4:0] GLYPH_L     = 5'd17;
   localparam logic [4:0] GLYPH_P     = 5'd18;
   localparam logic [4:0] GLYPH_DASH  = 5'd19;
   localparam logic [4:0] GLYPH_UNDER = 5'd20;
   localparam logic [4:0] GLYPH_BLANK = 5'd31;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // One digit's display attributes as captured from the host.
   typedef struct packed {
      logic [4:0] code;
      logic       dp;
      logic       blink;
   } digit_t;

   localparam digit_t DIGIT_RESET = '{code: GLYPH_BLANK, dp: 1'b0, blink: 1'b0};

endpackage

// File: rtl/seg_glyph_rom.sv
// Glyph code to active-low segment pattern, ordered {a,b,c,d,e,f,g}.
module seg_glyph_rom
   import seg_pkg::*;
(
   input  logic [4:0] code_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      unique case (code_i)
         5'd0:        seg_n_o = 7'b000_0001;
         5'd1:        seg_n_o = 7'b100_1111;
         5'd2:        seg_n_o = 7'b001_0010;
         5'd3:        seg_n_o = 7'b000_0110;
         5'd4:        seg_n_o = 7'b100_1100;
         5'd5:        seg_n_o = 7'b010_0100;
         5'd6:        seg_n_o = 7'b010_0000;
         5'd7:        seg_n_o = 7'b000_1111;
         5'd8:        seg_n_o = 7'b000_0000;
         5'd9:        seg_n_o = 7'b000_0100;
         5'd10:       seg_n_o = 7'b000_1000;
         5'd11:       seg_n_o = 7'b110_0000;
         5'd12:       seg_n_o = 7'b011_0001;
         5'd13:       seg_n_o = 7'b100_0010;
         5'd14:       seg_n_o = 7'b011_0000;
         5'd15:       seg_n_o = 7'b011_1000;
         GLYPH_H:     seg_n_o = 7'b100_1000;
         GLYPH_L:     seg_n_o = 7'b111_0001;
         GLYPH_P:     seg_n_o = 7'b001_1000;
         GLYPH_DASH:  seg_n_o = 7'b111_1110;
         GLYPH_UNDER: seg_n_o = 7'b111_0111;
         default:     seg_n_o = 7'b111_1111;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double
// buffering of host data and per-digit blinking.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 65536,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                    MCLK,
   input  logic                    RESETN,
   input  logic [5*NUM_DIGITS-1:0] DATA,
   input  logic [NUM_DIGITS-1:0]   DP,
   input  logic [NUM_DIGITS-1:0]   BLINK,
   input  logic                    LOAD,
   output logic                    PENDING,
   output logic                    FRAME_TICK,
   output logic [NUM_DIGITS-1:0]   ANODE,
   output logic [7:0]              SEG
);

   localparam int PSC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PSC_W-1:0]      psc_q, psc_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [FRM_W-1:0]      frm_q, frm_d;
   logic                  phase_q, phase_d;
   logic                  pending_q, pending_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [7:0]            seg_q, seg_d;
   digit_t                pnd_q [NUM_DIGITS];
   digit_t                pnd_d [NUM_DIGITS];
   digit_t                act_q [NUM_DIGITS];
   digit_t                act_d [NUM_DIGITS];
   digit_t                in_dig [NUM_DIGITS];

   logic       terminal;
   logic       last_slot;
   logic       boundary;
   digit_t     cur_dig;
   logic [6:0] glyph_n;

   assign terminal  = (psc_q == PSC_W'(CLK_DIV - 1));
   assign last_slot = (slot_q == SLOT_W'(NUM_DIGITS - 1));
   assign boundary  = terminal && last_slot;
   assign cur_dig   = act_q[slot_q];

   seg_glyph_rom u_rom (
      .code_i  (cur_dig.code),
      .seg_n_o (glyph_n)
   );

   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         in_dig[k] = '{code: DATA[5*k +: 5], dp: DP[k], blink: BLINK[k]};
      end
   end

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path through this block can infer a latch.
      psc_d     = terminal ? '0 : psc_q + PSC_W'(1);
      slot_d    = slot_q;
      frm_d     = frm_q;
      phase_d   = phase_q;
      pending_d = pending_q;
      pnd_d     = pnd_q;
      act_d     = act_q;

      if (terminal) begin
         slot_d = last_slot ? '0 : slot_q + SLOT_W'(1);
      end

      if (boundary) begin
         if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + FRM_W'(1);
         end
      end

      // A load on the boundary itself bypasses the pending set entirely.
      if (LOAD && boundary) begin
         act_d     = in_dig;
         pending_d = 1'b0;
      end else if (LOAD) begin
         pnd_d     = in_dig;
         pending_d = 1'b1;
      end else if (boundary && pending_q) begin
         act_d     = pnd_q;
         pending_d = 1'b0;
      end

      anode_d = ~(NUM_DIGITS'(1) << slot_q);
      seg_d   = (cur_dig.blink && phase_q) ? SEG_BLANK : {glyph_n, ~cur_dig.dp};
   end

   always_ff @(posedge MCLK or negedge RESETN) begin
      if (!RESETN) begin
         psc_q     <= '0;
         slot_q    <= '0;
         frm_q     <= '0;
         phase_q   <= 1'b0;
         pending_q <= 1'b0;
         anode_q   <= '1;
         seg_q     <= SEG_BLANK;
         // NOTE: the digit sets are flops, not RAM, and are reset so the display powers up blank.
         for (int k = 0; k < NUM_DIGITS; k++) begin
            pnd_q[k] <= DIGIT_RESET;
            act_q[k] <= DIGIT_RESET;
         end
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         psc_q     <= psc_d;
         slot_q    <= slot_d;
         frm_q     <= frm_d;
         phase_q   <= phase_d;
         pending_q <= pending_d;
         anode_q   <= anode_d;
         seg_q     <= seg_d;
         pnd_q     <= pnd_d;
         act_q     <= act_d;
      end
   end

   assign PENDING    = pending_q;
   assign FRAME_TICK = boundary;
   assign ANODE      = anode_q;
   assign SEG        = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: per-cycle comparison against a frame/slot arithmetic
// model, plus hand-computed pins for the directed scenarios.
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int CD = 4;
   localparam int BF = 2;

   logic        MCLK   = 1'b0;
   logic        RESETN = 1'b0;
   logic [19:0] DATA   = '0;
   logic [3:0]  DP     = '0;
   logic [3:0]  BLINK  = '0;
   logic        LOAD   = 1'b0;
   logic        PENDING;
   logic        FRAME_TICK;
   logic [3:0]  ANODE;
   logic [7:0]  SEG;

   int checks = 0;
   int errors = 0;

   seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
      .MCLK       (MCLK),
      .RESETN     (RESETN),
      .DATA       (DATA),
      .DP         (DP),
      .BLINK      (BLINK),
      .LOAD       (LOAD),
      .PENDING    (PENDING),
      .FRAME_TICK (FRAME_TICK),
      .ANODE      (ANODE),
      .SEG        (SEG)
   );

   always #5 MCLK = ~MCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lit segments of each glyph, by letter.
   function automatic string glyph_letters(input int code);
      case (code)
         0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
         4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
         8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
         12: return "adef";    13: return "bcdeg";  14: return "adefg";  15: return "aefg";
         16: return "bcefg";   17: return "def";    18: return "abefg";  19: return "g";
         20: return "d";
         default: return "";
      endcase
   endfunction

   function automatic logic [6:0] letters_to_seg(input string s);
      logic [6:0] r;
      r = 7'h7F;
      for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b0;
      return r;
   endfunction

   function automatic bit is_boundary(input int n);
      return ((n % CD) == CD - 1) && (((n / CD) % ND) == ND - 1);
   endfunction

   typedef struct {
      int code;
      bit dp;
      bit blink;
   } dig_t;

   dig_t m_act [ND];
   dig_t m_pnd [ND];
   bit   m_pending;
   int   e;
   bit   edge_live = 1'b0;

   initial forever begin
      @(posedge MCLK);
      edge_live = RESETN;
   end

   // Compare process: e counts live edges since reset release.
   initial begin
      int         s;
      int         ph;
      logic [3:0] exp_anode;
      logic [7:0] exp_seg;
      forever begin
         @(negedge MCLK);
         if (!RESETN || !edge_live) begin
            if (!RESETN) begin
               check("rst_anode", ANODE, 4'hF);
               check("rst_seg", SEG, 8'hFF);
               check("rst_pending", PENDING, 1'b0);
               check("rst_tick", FRAME_TICK, 1'b0);
            end
            for (int k = 0; k < ND; k++) begin
               m_act[k] = '{code: 31, dp: 1'b0, blink: 1'b0};
               m_pnd[k] = '{code: 31, dp: 1'b0, blink: 1'b0};
            end
            m_pending = 1'b0;
            e = 0;
         end else begin
            s  = (e / CD) % ND;
            ph = ((e / (CD * ND)) / BF) % 2;
            exp_anode = 4'hF;
            exp_anode[s] = 1'b0;
            if (m_act[s].blink && ph == 1) exp_seg = 8'hFF;
            else exp_seg = {letters_to_seg(glyph_letters(m_act[s].code)), ~m_act[s].dp};
            if (LOAD && is_boundary(e)) begin
               for (int k = 0; k < ND; k++) m_act[k] = '{code: int'(DATA[5*k +: 5]), dp: DP[k], blink: BLINK[k]};
               m_pending = 1'b0;
            end else if (LOAD) begin
               for (int k = 0; k < ND; k++) m_pnd[k] = '{code: int'(DATA[5*k +: 5]), dp: DP[k], blink: BLINK[k]};
               m_pending = 1'b1;
            end else if (is_boundary(e) && m_pending) begin
               m_act = m_pnd;
               m_pending = 1'b0;
            end
            e++;
            check("anode", ANODE, exp_anode);
            check("seg", SEG, exp_seg);
            check("pending", PENDING, m_pending);
            check("frame_tick", FRAME_TICK, is_boundary(e));
         end
      end
   end

   task automatic cyc();
      @(negedge MCLK);
      #1;
   endtask

   task automatic do_load(input logic [19:0] d, input logic [3:0] dp, input logic [3:0] bl);
      DATA  = d;
      DP    = dp;
      BLINK = bl;
      LOAD  = 1'b1;
      cyc();
      LOAD  = 1'b0;
   endtask

   task automatic wait_anode(input logic [3:0] a, input string name);
      int n;
      n = 0;
      while (ANODE !== a && n < 100) begin
         cyc();
         n++;
      end
      check({name, "_timeout"}, (n < 100), 1'b1);
   endtask

   initial begin
      int ticks;
      int blank1;
      int shown1;
      int bad_other;
      int n;

      repeat (3) cyc();
      check("lit_rst_anode", ANODE, 4'hF);
      check("lit_rst_seg", SEG, 8'hFF);
      RESETN = 1'b1;
      cyc();
      check("lit_first_anode", ANODE, 4'b1110);
      check("lit_first_seg", SEG, 8'hFF);

      // Idle scan: two frame ticks every 32 cycles.
      ticks = 0;
      for (int i = 0; i < 32; i++) begin
         if (FRAME_TICK === 1'b1) ticks++;
         cyc();
      end
      check("lit_tick_count", ticks, 2);

      // Mid-frame load waits for the boundary.
      wait_anode(4'b1101, "w31a");
      do_load({5'd16, 5'd15, 5'd0, 5'd8}, 4'b0001, 4'b0000);
      check("lit_pending_set", PENDING, 1'b1);
      wait_anode(4'b1110, "w31b");
      check("lit_pending_clr", PENDING, 1'b0);
      check("lit_dig0_8dp", SEG, 8'h00);
      wait_anode(4'b1101, "w31c");
      check("lit_dig1_0", SEG, 8'h03);
      wait_anode(4'b1011, "w31d");
      check("lit_dig2_F", SEG, 8'h71);
      wait_anode(4'b0111, "w31e");
      check("lit_dig3_H", SEG, 8'h91);

      // Two loads in one frame: the later wins.
      wait_anode(4'b1110, "w32a");
      do_load({4{5'd1}}, 4'b0000, 4'b0000);
      do_load({4{5'd2}}, 4'b0000, 4'b0000);
      check("lit_pending_two", PENDING, 1'b1);
      wait_anode(4'b0111, "w32b");
      wait_anode(4'b1110, "w32c");
      check("lit_last_write", SEG, 8'h25);

      // Load coinciding with the boundary bypasses the pending set.
      n = 0;
      while (FRAME_TICK !== 1'b1 && n < 100) begin
         cyc();
         n++;
      end
      check("tick_wait_timeout", (n < 100), 1'b1);
      do_load({4{5'd10}}, 4'b0000, 4'b0000);
      check("lit_bypass_pending", PENDING, 1'b0);
      check("lit_bypass_anode", ANODE, 4'b0111);
      cyc();
      check("lit_bypass_anode0", ANODE, 4'b1110);
      check("lit_bypass_seg", SEG, 8'h11);

      // Blink digit1 over eight whole frames: half blank, half showing 3.
      do_load({4{5'd3}}, 4'b0000, 4'b0010);
      wait_anode(4'b0111, "w34a");
      wait_anode(4'b1110, "w34b");
      blank1 = 0;
      shown1 = 0;
      bad_other = 0;
      for (int i = 0; i < 8 * CD * ND; i++) begin
         if (ANODE === 4'b1101) begin
            if (SEG === 8'hFF) blank1++;
            if (SEG === 8'h0D) shown1++;
         end else if (SEG !== 8'h0D) begin
            bad_other++;
         end
         cyc();
      end
      check("lit_blink_off", blank1, 16);
      check("lit_blink_on", shown1, 16);
      check("lit_blink_others", bad_other, 0);

      // Randomized loads; the compare process checks every cycle.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            do_load(20'($urandom), 4'($urandom), 4'($urandom));
         end else begin
            cyc();
         end
      end

      // Reset while data is pending.
      wait_anode(4'b1101, "w35a");
      do_load({4{5'd7}}, 4'b1111, 4'b0000);
      check("lit_pre_rst_pending", PENDING, 1'b1);
      RESETN = 1'b0;
      #1;
      check("lit_async_anode", ANODE, 4'hF);
      check("lit_async_seg", SEG, 8'hFF);
      check("lit_async_pending", PENDING, 1'b0);
      repeat (2) cyc();
      RESETN = 1'b1;
      cyc();
      check("lit_post_rst_pending", PENDING, 1'b0);
      check("lit_post_rst_anode", ANODE, 4'b1110);
      check("lit_post_rst_seg", SEG, 8'hFF);
      repeat (2 * CD * ND) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
